// File: rtl/net_pkg.sv
// Shared types and constants for the net inference core and its launcher.
package net_pkg;

  localparam int unsigned LANE_W = 32;

  localparam logic [LANE_W-1:0] FP_ZERO = 32'h0000_0000;
  localparam logic [LANE_W-1:0] FP_ONE  = 32'h3f80_0000;

  typedef enum logic [2:0] {
    IDLE,
    PRE,
    LAUNCH,
    RUN,
    HOLD
  } net_state_e;

endpackage

// File: rtl/net_sequencer_if.sv
// Vector input channel, result output channel and core handshake of net_sequencer.
interface net_sequencer_if #(
  parameter int unsigned I = 2,
  parameter int unsigned O = 1
);
  import net_pkg::*;

  localparam int unsigned XW = LANE_W * I;
  localparam int unsigned YW = LANE_W * O;

  logic          in_valid;
  logic          in_ready;
  logic [XW-1:0] in_x;
  logic          net_rst_n;
  logic          net_start;
  logic [XW-1:0] net_x;
  logic [YW-1:0] net_y;
  logic          net_done;
  logic          out_valid;
  logic          out_ready;
  logic [XW-1:0] out_x;
  logic [YW-1:0] out_y;
  logic          out_err;

  // master: host plus core side; slave: the sequencer itself
  modport master (
    output in_valid, in_x, out_ready, net_y, net_done,
    input  in_ready, net_rst_n, net_start, net_x, out_valid, out_x, out_y, out_err
  );

  modport slave (
    input  in_valid, in_x, out_ready, net_y, net_done,
    output in_ready, net_rst_n, net_start, net_x, out_valid, out_x, out_y, out_err
  );

endinterface

// File: rtl/net_seq_fifo.sv
// Synchronous FIFO for pending input vectors; head is read combinationally from storage.
module net_seq_fifo #(
  parameter int unsigned W     = 64,
  parameter int unsigned DEPTH = 4
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         push,
  input  logic         pop,
  input  logic [W-1:0] din,
  output logic [W-1:0] head,
  output logic         full,
  output logic         empty
);

  localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CW = AW + 1;

  logic [W-1:0]  mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [CW-1:0] count;
  logic          do_push;
  logic          do_pop;

  assign full    = (count == CW'(DEPTH));
  assign empty   = (count == '0);
  assign do_push = push & ~full;
  assign do_pop  = pop & ~empty;
  assign head    = mem[rd_ptr];

  // Power-of-two depth lets the pointers wrap naturally
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + AW'(1);
      if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
      count <= count + CW'(do_push) - CW'(do_pop);
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= din;
  end

endmodule

// File: rtl/net_sequencer.sv
// Launcher for the net core: queues vectors, sequences reset/start/done per vector.
// Optional RUN timeout watchdog compiled in with NET_SEQ_WATCHDOG_EN.
module net_sequencer
  import net_pkg::*;
#(
  parameter int unsigned I       = 2,
  parameter int unsigned O       = 1,
  parameter int unsigned DEPTH   = 4,
  parameter int unsigned RST_CYC = 5,
  parameter int unsigned TIMEOUT = 1024
) (
  input logic            clk,
  input logic            rst,
  net_sequencer_if.slave bus
);

  localparam int unsigned XW = LANE_W * I;
  localparam int unsigned YW = LANE_W * O;
  localparam int unsigned PW = (RST_CYC > 1) ? $clog2(RST_CYC) : 1;

  net_state_e    state;
  logic [PW-1:0] pre_cnt;
  logic          done_q;
  logic          rst_n_q;
  logic          start_q;
  logic          valid_q;
  logic          err_q;
  logic [XW-1:0] x_q;
  logic [XW-1:0] out_x_q;
  logic [YW-1:0] out_y_q;

  logic          push;
  logic          pre_last;
  logic          done_rise;
  logic          full;
  logic          empty;
  logic [XW-1:0] head;

  assign push      = bus.in_valid & bus.in_ready;
  assign pre_last  = (state == PRE) && (pre_cnt == PW'(RST_CYC - 1));
  assign done_rise = bus.net_done & ~done_q;

  assign bus.in_ready  = ~full & ~rst;
  assign bus.net_rst_n = rst_n_q;
  assign bus.net_start = start_q;
  assign bus.net_x     = x_q;
  assign bus.out_valid = valid_q;
  assign bus.out_x     = out_x_q;
  assign bus.out_y     = out_y_q;
  assign bus.out_err   = err_q;

  net_seq_fifo #(
    .W     (XW),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (push),
    .pop   (pre_last),
    .din   (bus.in_x),
    .head  (head),
    .full  (full),
    .empty (empty)
  );

`ifdef NET_SEQ_WATCHDOG_EN
  localparam int unsigned WW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  logic [WW-1:0] wd_cnt;
  logic          wd_expired;
  assign wd_expired = (wd_cnt == WW'(TIMEOUT - 1));
`else
  logic unused_timeout;
  assign unused_timeout = ^TIMEOUT;
`endif

  // Sequencer FSM; every core-facing and result output is a register
  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= IDLE;
      pre_cnt <= '0;
      done_q  <= 1'b0;
      rst_n_q <= 1'b0;
      start_q <= 1'b0;
      valid_q <= 1'b0;
      err_q   <= 1'b0;
      x_q     <= '0;
      out_x_q <= '0;
      out_y_q <= '0;
`ifdef NET_SEQ_WATCHDOG_EN
      wd_cnt  <= '0;
`endif
    end else begin
      done_q  <= bus.net_done;
      start_q <= 1'b0;
      case (state)
        IDLE: begin
          if (!empty) begin
            state   <= PRE;
            pre_cnt <= '0;
          end
        end
        PRE: begin
          if (pre_last) begin
            state   <= LAUNCH;
            start_q <= 1'b1;
            x_q     <= head;
          end else begin
            pre_cnt <= pre_cnt + PW'(1);
          end
        end
        LAUNCH: begin
          state   <= RUN;
          rst_n_q <= 1'b1;
`ifdef NET_SEQ_WATCHDOG_EN
          wd_cnt  <= '0;
`endif
        end
        RUN: begin
          // A done edge takes priority over a simultaneous timeout
          if (done_rise) begin
            state   <= HOLD;
            rst_n_q <= 1'b0;
            valid_q <= 1'b1;
            out_x_q <= x_q;
            out_y_q <= bus.net_y;
            err_q   <= 1'b0;
          end
`ifdef NET_SEQ_WATCHDOG_EN
          else if (wd_expired) begin
            state   <= HOLD;
            rst_n_q <= 1'b0;
            valid_q <= 1'b1;
            out_x_q <= x_q;
            out_y_q <= '0;
            err_q   <= 1'b1;
          end else begin
            wd_cnt <= wd_cnt + WW'(1);
          end
`endif
        end
        HOLD: begin
          if (bus.out_ready) begin
            valid_q <= 1'b0;
            pre_cnt <= '0;
            state   <= empty ? IDLE : PRE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: doc/net_sequencer.md
# net_sequencer

Upstream launcher for the `net` inference core. Buffers input vectors in a small FIFO and runs the core's start/reset protocol per vector: hold the core in reset, pulse `start` with the vector, release reset, wait for `done`. It then returns `y`, together with the vector that produced it, over a valid/ready output channel. A test or host can therefore stream XOR-style float vectors back to back without driving the core's handshake by hand.

## Interface
- I, 2, input count; input vector is 32*I bits, IEEE-754 single per lane, lane 0 in bits [31:0]
- O, 1, output count; result is 32*O bits
- DEPTH, 4, input FIFO depth in entries; must be a power of two, ≥2
- RST_CYC, 5, cycles `net_rst_n` is held low before each launch; must be ≥1
- TIMEOUT, 1024, cycles the RUN state waits for `net_done`; used only with the watchdog compiled in
- clk  in  1  single clock, all logic on posedge
- rst  in  1  synchronous, active-high reset
- in_valid  in  1  input vector offered
- in_ready  out  1  FIFO can accept; equals !full & !rst
- in_x  in  32*I  input vector
- net_rst_n  out  1  drives core `rst_n`
- net_start  out  1  drives core `start`
- net_x  out  32*I  drives core `x`; held stable from LAUNCH until leaving RUN
- net_y  in  32*O  core `y`
- net_done  in  1  core `done`, treated as a level; a registered rising edge completes a run
- out_valid  out  1  result available
- out_ready  in  1  consumer accepts result
- out_x  out  32*I  vector that produced the result
- out_y  out  32*O  captured core output
- out_err  out  1  result is a timeout abort; tied to 0 without the watchdog

## Operation
- FIFO: push on in_valid & in_ready. Pop exactly once per vector, on entry to LAUNCH. Push and pop in the same cycle are both allowed when not full. Pointers wrap modulo DEPTH. A push while full is impossible, because in_ready is 0.
- FSM states: IDLE, PRE, LAUNCH, RUN, HOLD.
- IDLE: net_rst_n=0, net_start=0. Go to PRE when the FIFO is non-empty.
- PRE: net_rst_n=0. A counter runs 0..RST_CYC-1. On the last count, go to LAUNCH.
- LAUNCH, one cycle: net_rst_n=0, net_start=1, net_x = FIFO head (registered at entry). Pop the FIFO. Go to RUN.
- RUN: net_rst_n=1, net_start=0.
  - done_q is net_done registered. When net_done & !done_q, capture net_y into out_y and net_x into out_x, clear out_err, and go to HOLD.
  - A net_done already high on RUN entry does not count, because done_q still holds the earlier value. Only a fresh edge completes the run.
- HOLD: out_valid=1 and net_rst_n=0. Leave HOLD on out_ready: go to PRE if the FIFO is non-empty, else IDLE. out_x, out_y and out_err stay stable while out_valid=1.
- net_done edges outside RUN are ignored.
- Reset:
  - Values during and after rst: net_rst_n=0, net_start=0, net_x=0, out_valid=0, out_x=0, out_y=0, out_err=0, FSM in IDLE, FIFO empty, counters 0.
  - rst mid-run discards the in-flight vector and all buffered vectors.

## Timing
- A vector accepted at edge t with the FIFO empty and the FSM idle goes through these states:
  - IDLE at t+1
  - PRE for cycles t+2 .. t+1+RST_CYC
  - LAUNCH at t+2+RST_CYC
  - RUN from t+3+RST_CYC
- If net_done rises in RUN cycle r, the FSM is in HOLD with out_valid=1 at cycle r+1.
- Back-to-back: the next PRE begins the cycle after the out_valid & out_ready handshake.
- Throughput per vector: RST_CYC + 2 + core latency + 1 + output stall.
- net_start is high for exactly one cycle per vector, always while net_rst_n=0. net_rst_n rises on the following cycle.

## Configuration
- NET_SEQ_WATCHDOG_EN defined:
  - A counter in RUN clears on RUN entry.
  - If TIMEOUT cycles pass with no done edge, go to HOLD with out_err=1, out_y=0, out_x = the launched vector.
  - A done edge in the same cycle as expiry wins: normal result, out_err=0.
- NET_SEQ_WATCHDOG_EN undefined: RUN waits indefinitely, no counter is built, out_err is constant 0.

## Structure
- Shared package net_pkg holds:
  - the FSM state enum (IDLE, PRE, LAUNCH, RUN, HOLD)
  - the float constants FP_ZERO = 32'h00000000 and FP_ONE = 32'h3f800000
  - the lane width localparam 32
- One sub-module, net_seq_fifo: synchronous FIFO with parameters W and DEPTH, push/pop/full/empty ports and a head output that is combinational from storage.

## Test plan
- Single vector: push {FP_ONE, FP_ZERO}, stub core raises done 10 cycles after start, returning 32'h3f800000.
  - Expect net_start high for exactly one cycle at t+2+RST_CYC, with net_rst_n=0 in that cycle.
  - Expect out_y=3f800000 and out_x echoing the input.
- XOR sweep: push 00/01/10/11 pairs back to back with the real `net` (I=2, H=4, O=1).
  - Expect four in-order results, and in_ready=0 only when DEPTH entries are pending.
- Backpressure: hold out_ready=0 for 20 cycles in HOLD. Expect out_valid, out_x and out_y stable, and no new net_start until the handshake.
- Stale done: stub holds net_done=1 across LAUNCH into RUN, then drops it and raises it again at RUN+5. Expect capture only on the second edge.
- Mid-run reset: rst for 1 cycle during RUN with 3 vectors queued.
  - Expect net_rst_n=0, out_valid=0 and in_ready=1 the cycle after.
  - Expect no results from the discarded vectors.
- Watchdog (NET_SEQ_WATCHDOG_EN, TIMEOUT=16): stub never raises done.
  - Expect HOLD at RUN+16 with out_err=1 and out_y=0.
  - Repeat with done rising at exactly the expiry cycle: expect out_err=0.
